// File: rtl/ex_stage.sv
// ex_stage: execute stage with ALU, branch resolve and an iterative MUL/DIV unit owning HI/LO.
// Define EX_MTHILO_EN to add MTHI/MTLO (funct 0x11/0x13), which write HI/LO from rs.
module ex_stage #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rrex_regwrite,
    input  logic             rrex_regdst,
    input  logic             rrex_aluop,
    input  logic             rrex_memread,
    input  logic             rrex_memwrite,
    input  logic             rrex_memtoreg,
    input  logic             rrex_branch,
    input  logic [WIDTH-1:0] rrex_pc,
    input  logic [WIDTH-1:0] rrex_data1,
    input  logic [WIDTH-1:0] rrex_data2,
    input  logic [WIDTH-1:0] rrex_extended16,
    input  logic [4:0]       rrex_rs,
    input  logic [4:0]       rrex_rt,
    input  logic [4:0]       rrex_rd,
    input  logic [25:0]      rrex_address,
    output logic             ex_stall,
    output logic             exmem_regwrite,
    output logic             exmem_memread,
    output logic             exmem_memwrite,
    output logic             exmem_memtoreg,
    output logic [WIDTH-1:0] exmem_alu_result,
    output logic [WIDTH-1:0] exmem_store_data,
    output logic [4:0]       exmem_dest,
    output logic             exmem_branch_taken,
    output logic [WIDTH-1:0] exmem_branch_target
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;
`ifdef EX_MTHILO_EN
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } md_state_e;

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d, dvs_q, dvs_d, dividend_q, dividend_d;
    logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic               div_zero_q, div_zero_d;

    logic               exmem_regwrite_q, exmem_regwrite_d;
    logic               exmem_memread_q, exmem_memread_d;
    logic               exmem_memwrite_q, exmem_memwrite_d;
    logic               exmem_memtoreg_q, exmem_memtoreg_d;
    logic [WIDTH-1:0]   exmem_alu_result_q, exmem_alu_result_d;
    logic [WIDTH-1:0]   exmem_store_data_q, exmem_store_data_d;
    logic [4:0]         exmem_dest_q, exmem_dest_d;
    logic               exmem_branch_taken_q, exmem_branch_taken_d;
    logic [WIDTH-1:0]   exmem_branch_target_q, exmem_branch_target_d;

    logic [5:0]         funct;
    logic [4:0]         shamt;
    logic               is_md, is_mthi, is_mtlo, is_dep, md_signed, md_bubble;
    logic [WIDTH-1:0]   alu_res, mag_a, mag_b;
    logic [2*WIDTH-1:0] mul_sum, mul_fin;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH-1:0]   div_quo, quo_fin, rem_fin;
    logic               unused_bits;

    assign unused_bits = ^{rrex_address, rrex_rs};

    // Decode; HI/LO readers and writers are the only instructions that wait on the MD unit.
    always_comb begin
        funct   = rrex_extended16[5:0];
        shamt   = rrex_extended16[10:6];
        is_md   = rrex_aluop && (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
`ifdef EX_MTHILO_EN
        is_mthi = rrex_aluop && (funct == F_MTHI);
        is_mtlo = rrex_aluop && (funct == F_MTLO);
`endif
        is_dep    = is_md || is_mthi || is_mtlo ||
                    (rrex_aluop && ((funct == F_MFHI) || (funct == F_MFLO)));
        ex_stall  = (state_q != S_IDLE) && is_dep;
        md_bubble = is_md || is_mthi || is_mtlo;
    end

    always_comb begin
        alu_res = '0;
        if (!rrex_aluop) begin
            alu_res = rrex_data1 + rrex_extended16;
        end else begin
            case (funct)
                F_ADD, F_ADDU: alu_res = rrex_data1 + rrex_data2;
                F_SUB, F_SUBU: alu_res = rrex_data1 - rrex_data2;
                F_AND:         alu_res = rrex_data1 & rrex_data2;
                F_OR:          alu_res = rrex_data1 | rrex_data2;
                F_XOR:         alu_res = rrex_data1 ^ rrex_data2;
                F_NOR:         alu_res = ~(rrex_data1 | rrex_data2);
                F_SLT:         alu_res = {{(WIDTH-1){1'b0}}, $signed(rrex_data1) < $signed(rrex_data2)};
                F_SLTU:        alu_res = {{(WIDTH-1){1'b0}}, rrex_data1 < rrex_data2};
                F_SLL:         alu_res = rrex_data2 << shamt;
                F_SRL:         alu_res = rrex_data2 >> shamt;
                F_SRA:         alu_res = $signed(rrex_data2) >>> shamt;
                F_MFHI:        alu_res = hi_q;
                F_MFLO:        alu_res = lo_q;
                default:       alu_res = '0;
            endcase
        end
    end

    // One iteration of shift-add multiply and restoring divide, BITS_PER_CYCLE bits at a time.
    always_comb begin
        md_signed = (funct == F_MULT) || (funct == F_DIV);
        mag_a     = (md_signed && rrex_data1[WIDTH-1]) ? -rrex_data1 : rrex_data1;
        mag_b     = (md_signed && rrex_data2[WIDTH-1]) ? -rrex_data2 : rrex_data2;

        mul_sum = prod_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                mul_sum = mul_sum + (mcand_q << i);
            end
        end
        mul_fin = neg_lo_q ? -mul_sum : mul_sum;

        div_rem = rem_q;
        div_quo = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            div_rem = {div_rem[WIDTH-1:0], div_quo[WIDTH-1]};
            div_quo = {div_quo[WIDTH-2:0], 1'b0};
            if (div_rem >= {1'b0, dvs_q}) begin
                div_rem    = div_rem - {1'b0, dvs_q};
                div_quo[0] = 1'b1;
            end
        end
        quo_fin = neg_lo_q ? -div_quo : div_quo;
        rem_fin = neg_hi_q ? -div_rem[WIDTH-1:0] : div_rem[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        mplier_d   = mplier_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        dividend_d = dividend_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        div_zero_d = div_zero_q;
        case (state_q)
            S_IDLE: begin
                if (is_md) begin
                    state_d    = ((funct == F_MULT) || (funct == F_MULTU)) ? S_MUL : S_DIV;
                    cnt_d      = '0;
                    mcand_d    = {{WIDTH{1'b0}}, mag_a};
                    mplier_d   = mag_b;
                    prod_d     = '0;
                    rem_d      = '0;
                    quo_d      = mag_a;
                    dvs_d      = mag_b;
                    dividend_d = rrex_data1;
                    neg_lo_d   = md_signed && (rrex_data1[WIDTH-1] ^ rrex_data2[WIDTH-1]);
                    neg_hi_d   = md_signed && rrex_data1[WIDTH-1];
                    div_zero_d = (rrex_data2 == '0);
                end
                if (is_mthi) hi_d = rrex_data1;
                if (is_mtlo) lo_d = rrex_data1;
            end
            S_MUL: begin
                prod_d   = mul_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                if (cnt_q == CNT_LAST) begin
                    state_d      = S_IDLE;
                    {hi_d, lo_d} = mul_fin;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DIV: begin
                rem_d = div_rem;
                quo_d = div_quo;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    lo_d    = div_zero_q ? '1 : quo_fin;
                    hi_d    = div_zero_q ? dividend_q : rem_fin;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A stalled instruction leaves a bubble; MD and MTHI/MTLO retire without a register write.
    always_comb begin
        exmem_regwrite_d      = rrex_regwrite && !ex_stall && !md_bubble;
        exmem_memread_d       = rrex_memread && !ex_stall;
        exmem_memwrite_d      = rrex_memwrite && !ex_stall;
        exmem_memtoreg_d      = rrex_memtoreg;
        exmem_alu_result_d    = alu_res;
        exmem_store_data_d    = rrex_data2;
        exmem_dest_d          = rrex_regdst ? rrex_rd : rrex_rt;
        exmem_branch_taken_d  = rrex_branch && (rrex_data1 == rrex_data2) && !ex_stall;
        exmem_branch_target_d = rrex_pc + (rrex_extended16 << 2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q               <= S_IDLE;
            cnt_q                 <= '0;
            hi_q                  <= '0;
            lo_q                  <= '0;
            mcand_q               <= '0;
            prod_q                <= '0;
            mplier_q              <= '0;
            rem_q                 <= '0;
            quo_q                 <= '0;
            dvs_q                 <= '0;
            dividend_q            <= '0;
            neg_lo_q              <= 1'b0;
            neg_hi_q              <= 1'b0;
            div_zero_q            <= 1'b0;
            exmem_regwrite_q      <= 1'b0;
            exmem_memread_q       <= 1'b0;
            exmem_memwrite_q      <= 1'b0;
            exmem_memtoreg_q      <= 1'b0;
            exmem_alu_result_q    <= '0;
            exmem_store_data_q    <= '0;
            exmem_dest_q          <= '0;
            exmem_branch_taken_q  <= 1'b0;
            exmem_branch_target_q <= '0;
        end else begin
            state_q               <= state_d;
            cnt_q                 <= cnt_d;
            hi_q                  <= hi_d;
            lo_q                  <= lo_d;
            mcand_q               <= mcand_d;
            prod_q                <= prod_d;
            mplier_q              <= mplier_d;
            rem_q                 <= rem_d;
            quo_q                 <= quo_d;
            dvs_q                 <= dvs_d;
            dividend_q            <= dividend_d;
            neg_lo_q              <= neg_lo_d;
            neg_hi_q              <= neg_hi_d;
            div_zero_q            <= div_zero_d;
            exmem_regwrite_q      <= exmem_regwrite_d;
            exmem_memread_q       <= exmem_memread_d;
            exmem_memwrite_q      <= exmem_memwrite_d;
            exmem_memtoreg_q      <= exmem_memtoreg_d;
            exmem_alu_result_q    <= exmem_alu_result_d;
            exmem_store_data_q    <= exmem_store_data_d;
            exmem_dest_q          <= exmem_dest_d;
            exmem_branch_taken_q  <= exmem_branch_taken_d;
            exmem_branch_target_q <= exmem_branch_target_d;
        end
    end

    assign exmem_regwrite      = exmem_regwrite_q;
    assign exmem_memread       = exmem_memread_q;
    assign exmem_memwrite      = exmem_memwrite_q;
    assign exmem_memtoreg      = exmem_memtoreg_q;
    assign exmem_alu_result    = exmem_alu_result_q;
    assign exmem_store_data    = exmem_store_data_q;
    assign exmem_dest          = exmem_dest_q;
    assign exmem_branch_taken  = exmem_branch_taken_q;
    assign exmem_branch_target = exmem_branch_target_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized bench for ex_stage, checked against an
// instruction-level model that tracks HI/LO and the remaining MD busy cycles.
`timescale 1ns/1ps
module tb_ex_stage;
    localparam int BPC = 1;
    localparam int N   = 32 / BPC;

    logic        clk = 1'b0;
    logic        reset;
    logic        rrex_regwrite, rrex_regdst, rrex_aluop, rrex_memread;
    logic        rrex_memwrite, rrex_memtoreg, rrex_branch;
    logic [31:0] rrex_pc, rrex_data1, rrex_data2, rrex_extended16;
    logic [4:0]  rrex_rs, rrex_rt, rrex_rd;
    logic [25:0] rrex_address;
    logic        ex_stall;
    logic        exmem_regwrite, exmem_memread, exmem_memwrite, exmem_memtoreg;
    logic [31:0] exmem_alu_result, exmem_store_data, exmem_branch_target;
    logic [4:0]  exmem_dest;
    logic        exmem_branch_taken;

    always #5 clk = ~clk;

    ex_stage #(.WIDTH(32), .BITS_PER_CYCLE(BPC)) dut (
        .clk(clk), .reset(reset),
        .rrex_regwrite(rrex_regwrite), .rrex_regdst(rrex_regdst), .rrex_aluop(rrex_aluop),
        .rrex_memread(rrex_memread), .rrex_memwrite(rrex_memwrite), .rrex_memtoreg(rrex_memtoreg),
        .rrex_branch(rrex_branch), .rrex_pc(rrex_pc), .rrex_data1(rrex_data1),
        .rrex_data2(rrex_data2), .rrex_extended16(rrex_extended16), .rrex_rs(rrex_rs),
        .rrex_rt(rrex_rt), .rrex_rd(rrex_rd), .rrex_address(rrex_address),
        .ex_stall(ex_stall), .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
        .exmem_memwrite(exmem_memwrite), .exmem_memtoreg(exmem_memtoreg),
        .exmem_alu_result(exmem_alu_result), .exmem_store_data(exmem_store_data),
        .exmem_dest(exmem_dest), .exmem_branch_taken(exmem_branch_taken),
        .exmem_branch_target(exmem_branch_target)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_busy = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic aluop, input logic regwrite, input logic regdst,
                                 input logic memread, input logic memwrite, input logic memtoreg,
                                 input logic branch, input logic [31:0] pc, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] ext,
                                 input logic [4:0] rt, input logic [4:0] rd);
        rrex_aluop = aluop;       rrex_regwrite = regwrite; rrex_regdst = regdst;
        rrex_memread = memread;   rrex_memwrite = memwrite; rrex_memtoreg = memtoreg;
        rrex_branch = branch;     rrex_pc = pc;             rrex_data1 = d1;
        rrex_data2 = d2;          rrex_extended16 = ext;    rrex_rt = rt;
        rrex_rd = rd;             rrex_rs = 5'($urandom);   rrex_address = 26'($urandom);
    endtask

    task automatic applyRtype(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [4:0] rd);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400, d1, d2,
                      {21'd0, sh, f}, 5'd9, rd);
    endtask

    task automatic applyNop();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    endtask

    // Spec-level ALU result for the instruction currently presented.
    function automatic logic [31:0] aluModel();
        logic [5:0] f;
        int         sh;
        f  = rrex_extended16[5:0];
        sh = int'(rrex_extended16[10:6]);
        if (!rrex_aluop) return rrex_data1 + rrex_extended16;
        case (f)
            6'h20, 6'h21: return rrex_data1 + rrex_data2;
            6'h22, 6'h23: return rrex_data1 - rrex_data2;
            6'h24: return rrex_data1 & rrex_data2;
            6'h25: return rrex_data1 | rrex_data2;
            6'h26: return rrex_data1 ^ rrex_data2;
            6'h27: return ~(rrex_data1 | rrex_data2);
            6'h2A: return ($signed(rrex_data1) < $signed(rrex_data2)) ? 32'd1 : 32'd0;
            6'h2B: return (rrex_data1 < rrex_data2) ? 32'd1 : 32'd0;
            6'h00: return rrex_data2 << sh;
            6'h02: return rrex_data2 >> sh;
            6'h03: return 32'($signed(rrex_data2) >>> sh);
            6'h10: return m_hi;
            6'h12: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    // Full-width arithmetic result of an MD op, as {HI, LO}.
    function automatic logic [63:0] mdModel(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            6'h18: return 64'(sa * sb);
            6'h19: return {32'd0, a} * {32'd0, b};
            6'h1A: if (b == 0) return {a, 32'hFFFFFFFF};
                   else return {32'(sa % sb), 32'(sa / sb)};
            default: if (b == 0) return {a, 32'hFFFFFFFF};
                     else return {a % b, a / b};
        endcase
    endfunction

    // One clock of the pipeline: check stall before the edge, advance the model, check EX/MEM after.
    task automatic stepCycle(input string tag, output logic exp_stall, output logic obs_stall);
        logic [5:0]  f;
        logic        md, mth, dep;
        logic [31:0] e_res, e_tgt;
        logic [4:0]  e_dest;
        logic [63:0] md_val;
        #1;
        f   = rrex_extended16[5:0];
        md  = rrex_aluop && (f >= 6'h18) && (f <= 6'h1B);
        mth = 1'b0;
`ifdef EX_MTHILO_EN
        mth = rrex_aluop && ((f == 6'h11) || (f == 6'h13));
`endif
        dep       = md || mth || (rrex_aluop && ((f == 6'h10) || (f == 6'h12)));
        exp_stall = (m_busy > 0) && dep;
        obs_stall = ex_stall;
        checkOutput({tag, " ex_stall"}, {31'd0, ex_stall}, {31'd0, exp_stall});
        e_res  = aluModel();
        e_tgt  = rrex_pc + (rrex_extended16 << 2);
        e_dest = rrex_regdst ? rrex_rd : rrex_rt;
        md_val = mdModel(f, rrex_data1, rrex_data2);
        @(posedge clk);
        if (reset) begin
            m_busy = 0;
            m_hi   = 0;
            m_lo   = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (md) begin
            {p_hi, p_lo} = md_val;
            m_busy       = N;
        end else if (mth) begin
            if (f == 6'h11) m_hi = rrex_data1;
            else m_lo = rrex_data1;
        end
        #1;
        if (reset) begin
            checkOutput({tag, " rst.regwrite"}, {31'd0, exmem_regwrite}, 32'd0);
            checkOutput({tag, " rst.memread"},  {31'd0, exmem_memread}, 32'd0);
            checkOutput({tag, " rst.memwrite"}, {31'd0, exmem_memwrite}, 32'd0);
            checkOutput({tag, " rst.memtoreg"}, {31'd0, exmem_memtoreg}, 32'd0);
            checkOutput({tag, " rst.result"},   exmem_alu_result, 32'd0);
            checkOutput({tag, " rst.store"},    exmem_store_data, 32'd0);
            checkOutput({tag, " rst.dest"},     {27'd0, exmem_dest}, 32'd0);
            checkOutput({tag, " rst.taken"},    {31'd0, exmem_branch_taken}, 32'd0);
            checkOutput({tag, " rst.target"},   exmem_branch_target, 32'd0);
        end else begin
            checkOutput({tag, " regwrite"}, {31'd0, exmem_regwrite},
                        {31'd0, rrex_regwrite && !exp_stall && !md && !mth});
            checkOutput({tag, " memread"},  {31'd0, exmem_memread}, {31'd0, rrex_memread && !exp_stall});
            checkOutput({tag, " memwrite"}, {31'd0, exmem_memwrite}, {31'd0, rrex_memwrite && !exp_stall});
            checkOutput({tag, " taken"},    {31'd0, exmem_branch_taken},
                        {31'd0, rrex_branch && (rrex_data1 == rrex_data2) && !exp_stall});
            if (!exp_stall) begin
                checkOutput({tag, " memtoreg"}, {31'd0, exmem_memtoreg}, {31'd0, rrex_memtoreg});
                checkOutput({tag, " store"},    exmem_store_data, rrex_data2);
                checkOutput({tag, " dest"},     {27'd0, exmem_dest}, {27'd0, e_dest});
                checkOutput({tag, " target"},   exmem_branch_target, e_tgt);
                if (!md && !mth) checkOutput({tag, " result"}, exmem_alu_result, e_res);
            end
        end
    endtask

    // Present one instruction, holding it while the model says it is stalled.
    task automatic issue(input string tag, output int stall_obs);
        logic es, os;
        int   guard;
        stall_obs = 0;
        guard     = 0;
        stepCycle(tag, es, os);
        if (os) stall_obs++;
        while (es && guard < 4 * N) begin
            guard++;
            stepCycle(tag, es, os);
            if (os) stall_obs++;
        end
        if (es) begin
            fails++;
            $display("[TB] FAIL %s stall_bound observed=still_stalled expected=released", tag);
        end
    endtask

    int          sc;
    logic        es0, os0;
    logic [5:0]  rfun [23] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18,
                               6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h3F, 6'h01};

    initial begin
        reset = 1'b1;
        applyNop();
        stepCycle("reset0", es0, os0);
        stepCycle("reset1", es0, os0);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h7FFFFFFF, 32'h1,
                      32'h0000_0020, 5'd3, 5'd5);
        issue("add_ovf", sc);
        checkOutput("add_ovf.const_result", exmem_alu_result, 32'h80000000);
        checkOutput("add_ovf.const_dest", {27'd0, exmem_dest}, 32'd5);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'd7, 32'd7, 32'hFFFFFFFC, 5'd0, 5'd0);
        issue("beq_taken", sc);
        checkOutput("beq_taken.const_target", exmem_branch_target, 32'h000000F0);
        checkOutput("beq_taken.const_taken", {31'd0, exmem_branch_taken}, 32'd1);
        rrex_data2 = 32'd8;
        issue("beq_not", sc);
        checkOutput("beq_not.const_taken", {31'd0, exmem_branch_taken}, 32'd0);

        applyRtype(6'h18, 5'd0, 32'hFFFFFFFE, 32'd3, 5'd0);
        issue("mult", sc);
        applyRtype(6'h10, 5'd0, 32'd0, 32'd0, 5'd4);
        issue("mfhi_mult", sc);
        checkOutput("mult.stall_cycles", sc, N);
        checkOutput("mult.const_hi", exmem_alu_result, 32'hFFFFFFFF);
        applyRtype(6'h12, 5'd0, 32'd0, 32'd0, 5'd4);
        issue("mflo_mult", sc);
        checkOutput("mult.const_lo", exmem_alu_result, 32'hFFFFFFFA);

        applyRtype(6'h1A, 5'd0, 32'hFFFFFFF9, 32'd2, 5'd0);
        issue("div", sc);
        applyRtype(6'h12, 5'd0, 32'd0, 32'd0, 5'd6);
        issue("mflo_div", sc);
        checkOutput("div.const_lo", exmem_alu_result, 32'hFFFFFFFD);
        applyRtype(6'h10, 5'd0, 32'd0, 32'd0, 5'd6);
        issue("mfhi_div", sc);
        checkOutput("div.const_hi", exmem_alu_result, 32'hFFFFFFFF);

        applyRtype(6'h1B, 5'd0, 32'd5, 32'd0, 5'd0);
        issue("divu0", sc);
        for (int i = 0; i < 5; i++) begin
            applyRtype(6'h21, 5'd0, $urandom, $urandom, 5'(i + 10));
            issue("add_busy", sc);
            checkOutput("add_busy.stall_cycles", sc, 0);
        end
        applyRtype(6'h12, 5'd0, 32'd0, 32'd0, 5'd7);
        issue("mflo_divu0", sc);
        checkOutput("divu0.const_lo", exmem_alu_result, 32'hFFFFFFFF);
        applyRtype(6'h10, 5'd0, 32'd0, 32'd0, 5'd7);
        issue("mfhi_divu0", sc);
        checkOutput("divu0.const_hi", exmem_alu_result, 32'd5);

        applyRtype(6'h18, 5'd0, 32'd1234, 32'd5678, 5'd0);
        issue("mult_abort", sc);
        applyNop();
        for (int i = 0; i < 9; i++) stepCycle("busy_nop", es0, os0);
        reset = 1'b1;
        stepCycle("mid_reset0", es0, os0);
        stepCycle("mid_reset1", es0, os0);
        reset = 1'b0;
        applyRtype(6'h12, 5'd0, 32'd0, 32'd0, 5'd8);
        issue("mflo_after_rst", sc);
        checkOutput("rst_abort.const_lo", exmem_alu_result, 32'd0);
        checkOutput("rst_abort.stall_cycles", sc, 0);
        applyRtype(6'h10, 5'd0, 32'd0, 32'd0, 5'd8);
        issue("mfhi_after_rst", sc);
        checkOutput("rst_abort.const_hi", exmem_alu_result, 32'd0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] d1, d2;
            int          r;
            r  = int'($urandom_range(0, 99));
            d1 = $urandom;
            d2 = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (r < 5) d2 = d1;
            if (r < 20) begin
                applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                              1'($urandom), 1'($urandom), $urandom, d1, d2,
                              {{16{d2[15]}}, 16'($urandom)}, 5'($urandom), 5'($urandom));
            end else begin
                applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, $urandom,
                              d1, d2, {21'($urandom), 5'($urandom), rfun[$urandom_range(0, 22)]},
                              5'($urandom), 5'($urandom));
            end
            issue("random", sc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 6-stage pipeline; consumes the RR/EX register outputs and produces the registered EX/MEM bundle.
- Contains:
  - single-cycle ALU;
  - branch compare / target adder;
  - iterative multiply/divide unit with HI/LO registers.
- Raises ex_stall to freeze RR/EX and earlier stages while a HI/LO-dependent instruction waits on the multi-cycle unit.

Parameters:
- WIDTH, 32, datapath width; only 32 supported.
- BITS_PER_CYCLE, 1, multiply/divide bits resolved per cycle (1, 2 or 4); MD latency N = WIDTH/BITS_PER_CYCLE.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- rrex_regwrite, rrex_regdst, rrex_aluop, rrex_memread, rrex_memwrite, rrex_memtoreg, rrex_branch  in  1 each  control from RR/EX.
- rrex_pc  in  32  PC+4 of instruction.
- rrex_data1, rrex_data2  in  32  rs / rt operand values.
- rrex_extended16  in  32  sign-extended immediate; [5:0]=funct, [10:6]=shamt for R-type.
- rrex_rs, rrex_rt, rrex_rd  in  5  register numbers.
- rrex_address  in  26  jump field; unused here.
- ex_stall  out  1  combinational; hold RR/EX and upstream this cycle.
- exmem_regwrite, exmem_memread, exmem_memwrite, exmem_memtoreg  out  1 each  registered controls.
- exmem_alu_result  out  32  registered ALU / MFHI / MFLO result.
- exmem_store_data  out  32  registered rrex_data2.
- exmem_dest  out  5  registered destination register.
- exmem_branch_taken  out  1  registered branch decision.
- exmem_branch_target  out  32  registered branch target.

Behaviour:
- Reset:
  - all exmem_* outputs = 0; HI = LO = 0; FSM = IDLE; ex_stall = 0.
  - Reset mid multiply/divide aborts it with no HI/LO update.
- Destination: exmem_dest = rrex_regdst ? rrex_rd : rrex_rt.
- rrex_aluop=0 (loads, stores, addi, beq): result = data1 + extended16.
- rrex_aluop=1 (R-type), funct selects the operation:
  - 0x20/0x21 add; 0x22/0x23 sub.
  - 0x24 and; 0x25 or; 0x26 xor; 0x27 nor.
  - 0x2A slt (signed); 0x2B sltu.
  - 0x00 sll, 0x02 srl, 0x03 sra of data2 by shamt.
  - 0x10 MFHI, 0x12 MFLO.
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
  - Any other funct gives result 0.
  - No overflow traps; all arithmetic wraps mod 2^32.
- Branch: taken = rrex_branch & (data1 == data2); target = rrex_pc + (extended16 << 2), mod 2^32.
- MD ops (0x18-0x1B):
  - Retire into EX/MEM immediately as a bubble (regwrite forced 0).
  - Capture operands and enter MUL or DIV for N cycles.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL/DIV on an accepted MD op.
  - MUL/DIV -> IDLE when the iteration counter reaches N-1; HI/LO are written on that same edge.
- MUL/DIV arithmetic:
  - Signed ops operate on magnitudes; sign is fixed on the final edge.
  - MULT: {HI,LO} = 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend; normal latency.
- ex_stall:
  - = (state != IDLE) & rrex_aluop & funct in {0x10, 0x12, 0x18-0x1B}.
  - When stalled: EX/MEM loads a bubble (regwrite, memread, memwrite, branch_taken = 0); no new MD op is accepted.
- Timing:
  - MD op accepted at edge t0 is busy in cycles t0+1..t0+N.
  - A dependent instruction first proceeds in cycle t0+N+1 and sees the new HI/LO.
- Non-dependent instructions flow without stall during busy cycles.
- EX/MEM register loads every cycle; there is no enable.

Optional Feature:
- Macro EX_MTHILO_EN.
  - Defined: funct 0x11 MTHI / 0x13 MTLO write HI/LO from rrex_data1 on the edge; retire as a bubble; they are added to the ex_stall dependent set while busy.
  - Undefined: 0x11/0x13 decode as unknown funct (result 0), HI/LO untouched, no stall.

Test Plan:
- Reset asserted 2 cycles mid-MULT (BITS_PER_CYCLE=1, cycle 10 of 32) -> all exmem_* = 0; MFLO after release returns 0; ex_stall = 0.
- ADD with data1=0x7FFFFFFF, data2=1, regdst=1, rd=5 -> next edge: exmem_alu_result = 0x80000000, exmem_dest = 5, exmem_regwrite = 1.
- beq, rrex_pc=0x100, imm=-4, data1=data2=7 -> exmem_branch_taken = 1, target = 0xF0; with data2=8 -> taken = 0.
- MULT 0xFFFFFFFE × 3, then MFHI, then MFLO (BITS_PER_CYCLE=1):
  - ex_stall high for exactly 32 cycles with bubbles in EX/MEM;
  - then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 5.
- Independent ADDs during DIV busy proceed with ex_stall = 0.
